// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_ctrl_pkg
//  Description : Shared types and constants for the EXE-stage divider issue
//                controller (state encoding, abort length, result slicing).
//  Revision    : 1.0  initial release
// ============================================================================
package div_ctrl_pkg;

    // Issue controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } div_state_t;

    // Number of cycles div_clr is held; a divide-by-zero in flight ignores
    // the first clear, so two are needed to guarantee an idle divider.
    localparam int unsigned ABORT_CYCLES   = 2;

    // Default watchdog bound in RUN cycles
    localparam int unsigned DEF_WDOG_LIMIT = 40;

    // Divider result layout: {remainder, quotient}
    localparam int unsigned RES_HI_MSB = 63;
    localparam int unsigned RES_HI_LSB = 32;
    localparam int unsigned RES_LO_MSB = 31;
    localparam int unsigned RES_LO_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_issue_ctrl
//  Description : EXE-stage issue controller for the multi-cycle divider.
//                Latches DIV/DIVU operands, drives start/clr/sign, stalls the
//                pipeline until the divider finishes and writes quotient to
//                LO and remainder to HI. An EXE flush aborts a running divide
//                with a two-cycle clear before the next request is accepted.
//                Optional RUN watchdog enabled by `define DIV_WATCHDOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ex_div_req,
    input  logic        i_ex_div_signed,
    input  logic [31:0] i_ex_rs,
    input  logic [31:0] i_ex_rt,
    input  logic        i_ex_flush,
    input  logic        i_ex_hold,
    output logic        o_div_start,
    output logic        o_div_clr,
    output logic        o_div_sign,
    output logic [31:0] o_div_a,
    output logic [31:0] o_div_b,
    input  logic        i_div_busy,
    input  logic [63:0] i_div_result,
    output logic        o_div_stall,
    output logic        o_hi_we,
    output logic        o_lo_we,
    output logic [31:0] o_hi_wdata,
    output logic [31:0] o_lo_wdata,
    output logic        o_div_err
);

    localparam logic [1:0] c_ABORT_LAST = 2'(ABORT_CYCLES - 1);

    div_state_t  r_state;
    div_state_t  w_next_state;

    logic        r_seen_busy;
    logic [1:0]  r_abort_cnt;
    logic        r_first_done;
    logic        r_div_start;
    logic        r_div_sign;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic [31:0] r_hi_wdata;
    logic [31:0] r_lo_wdata;

    logic        w_accept;
    logic        w_capture;
    logic        w_stall;
    logic        w_clr;
    logic        w_we;
    logic        w_err;
    logic        w_wdog_hit;

`ifdef DIV_WATCHDOG_EN
    localparam logic [5:0] c_WDOG_LAST = 6'(WDOG_LIMIT - 1);

    logic [5:0]  r_wdog_cnt;

    // Count RUN cycles; cleared whenever the controller is outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= 6'd0;
        end else if (r_state == ST_RUN) begin
            r_wdog_cnt <= r_wdog_cnt + 6'd1;
        end else begin
            r_wdog_cnt <= 6'd0;
        end
    end

    assign w_wdog_hit = (r_wdog_cnt == c_WDOG_LAST);
`else
    logic w_unused_wdog_cfg;

    assign w_unused_wdog_cfg = (WDOG_LIMIT == 0);
    assign w_wdog_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and combinational outputs
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_stall      = 1'b0;
        w_clr        = 1'b0;
        w_we         = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = i_ex_div_req & ~i_ex_flush;
                w_stall  = w_accept;
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_stall = 1'b1;
                if (i_ex_flush) begin
                    w_next_state = ST_ABORT;
                end else if (w_wdog_hit) begin
                    w_err        = 1'b1;
                    w_next_state = ST_ABORT;
                end else if (r_seen_busy && !i_div_busy) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // Write only once; a held instruction stays here rather than re-issuing
                w_we = r_first_done & ~i_ex_flush;
                if (i_ex_flush || !i_ex_hold) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ABORT: begin
                w_clr = 1'b1;
                if (r_abort_cnt == c_ABORT_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Track that the divider has actually gone busy before trusting busy low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen_busy <= 1'b0;
        end else if (r_state != ST_RUN) begin
            r_seen_busy <= 1'b0;
        end else if (i_div_busy) begin
            r_seen_busy <= 1'b1;
        end
    end

    // Abort length counter, restarted on every entry to ABORT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort_cnt <= 2'd0;
        end else if (r_state == ST_ABORT) begin
            r_abort_cnt <= r_abort_cnt + 2'd1;
        end else begin
            r_abort_cnt <= 2'd0;
        end
    end

    // Start is high exactly while in RUN; first-DONE flag marks the write cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_start  <= 1'b0;
            r_first_done <= 1'b0;
        end else begin
            r_div_start  <= (w_next_state == ST_RUN);
            r_first_done <= w_capture;
        end
    end

    // Operands are sampled only when a request is accepted in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_sign <= 1'b0;
            r_div_a    <= 32'd0;
            r_div_b    <= 32'd0;
        end else if (w_accept) begin
            r_div_sign <= i_ex_div_signed;
            r_div_a    <= i_ex_rs;
            r_div_b    <= i_ex_rt;
        end
    end

    // Capture divider result when it drops busy after having been busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_wdata <= 32'd0;
            r_lo_wdata <= 32'd0;
        end else if (w_capture) begin
            r_hi_wdata <= i_div_result[RES_HI_MSB:RES_HI_LSB];
            r_lo_wdata <= i_div_result[RES_LO_MSB:RES_LO_LSB];
        end
    end

    assign o_div_start = r_div_start;
    assign o_div_clr   = w_clr;
    assign o_div_sign  = r_div_sign;
    assign o_div_a     = r_div_a;
    assign o_div_b     = r_div_b;
    assign o_div_stall = w_stall;
    assign o_hi_we     = w_we;
    assign o_lo_we     = w_we;
    assign o_hi_wdata  = r_hi_wdata;
    assign o_lo_wdata  = r_lo_wdata;
    assign o_div_err   = w_err;

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_issue_ctrl
//  Description : Scoreboard bench for div_issue_ctrl with a behavioural
//                divider (34 busy cycles, 3 for a zero divisor).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_div_req;
    logic        ex_div_signed;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        ex_flush;
    logic        ex_hold;
    logic        div_start;
    logic        div_clr;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_busy;
    logic [63:0] div_result;
    logic        div_stall;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        div_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_writes = 0;
    logic [63:0] exp_q[$];
    logic        force_busy;

    div_issue_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_ex_div_req    (ex_div_req),
        .i_ex_div_signed (ex_div_signed),
        .i_ex_rs         (ex_rs),
        .i_ex_rt         (ex_rt),
        .i_ex_flush      (ex_flush),
        .i_ex_hold       (ex_hold),
        .o_div_start     (div_start),
        .o_div_clr       (div_clr),
        .o_div_sign      (div_sign),
        .o_div_a         (div_a),
        .o_div_b         (div_b),
        .i_div_busy      (div_busy),
        .i_div_result    (div_result),
        .o_div_stall     (div_stall),
        .o_hi_we         (hi_we),
        .o_lo_we         (lo_we),
        .o_hi_wdata      (hi_wdata),
        .o_lo_wdata      (lo_wdata),
        .o_div_err       (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: busy rises combinationally with start
    int   m_left;
    logic m_started;
    logic [31:0] m_q;
    logic [31:0] m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left    <= 0;
            m_started <= 1'b0;
        end else if (!div_start || div_clr) begin
            m_left    <= 0;
            m_started <= 1'b0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_left    <= (div_b == 32'd0) ? 2 : 33;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
        end
    end

    assign div_busy = force_busy | (div_start & (!m_started | (m_left != 0)));

    always_comb begin
        m_q = 32'd0;
        m_r = 32'd0;
        if (div_b != 32'd0) begin
            if (div_sign) begin
                m_q = $signed(div_a) / $signed(div_b);
                m_r = $signed(div_a) % $signed(div_b);
            end else begin
                m_q = div_a / div_b;
                m_r = div_a % div_b;
            end
        end
    end

    assign div_result = {m_r, m_q};

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: every HI/LO write is matched against the scoreboard queue
    always @(negedge clk) begin
        if (rst_n && (hi_we || lo_we)) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got hi=0x%0h lo=0x%0h expected no write", hi_wdata, lo_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("hi_wdata", {32'd0, hi_wdata}, {32'd0, e[63:32]});
                check("lo_wdata", {32'd0, lo_wdata}, {32'd0, e[31:0]});
                check("hi_we", {63'd0, hi_we}, 64'd1);
                check("lo_we", {63'd0, lo_we}, 64'd1);
            end
        end
    end

    // Issue one divide starting in the current cycle; returns one cycle after DONE
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int exp_stall, input int hold_cycles);
        int n;
        exp_q.push_back({eh, el});
        ex_div_req    = 1'b1;
        ex_div_signed = sgn;
        ex_rs         = a;
        ex_rt         = b;
        ex_hold       = (hold_cycles > 0);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 1) check("start_c1", {63'd0, div_start}, 64'd1);
            if (!div_stall) break;
            n++;
        end
        check("stall_len", n, exp_stall);
        check("start_done", {63'd0, div_start}, 64'd0);
        check("we_done", {63'd0, hi_we}, 64'd1);
        for (int i = 1; i <= hold_cycles; i++) begin
            @(posedge clk); #1;
            if (i == hold_cycles) ex_hold = 1'b0;
            @(negedge clk);
            check("hold_no_start", {63'd0, div_start}, 64'd0);
            check("hold_no_we", {63'd0, hi_we}, 64'd0);
            check("hold_no_stall", {63'd0, div_stall}, 64'd0);
        end
        @(posedge clk); #1;
        ex_div_req = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w0;
        rst_n = 1'b0; ex_div_req = 1'b0; ex_div_signed = 1'b0;
        ex_rs = 32'd0; ex_rt = 32'd0; ex_flush = 1'b0; ex_hold = 1'b0;
        force_busy = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_start", {63'd0, div_start}, 64'd0);
        check("rst_clr", {63'd0, div_clr}, 64'd0);
        check("rst_stall", {63'd0, div_stall}, 64'd0);
        check("rst_outs", {hi_wdata, lo_wdata}, 64'd0);
        check("rst_err", {63'd0, div_err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // DIV -7 / 2
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 36, 0);
        check("nowe_after", {63'd0, hi_we}, 64'd0);
        repeat (2) @(posedge clk); #1;

        // DIVU 100 / 7 followed back-to-back by DIVU 9 / 3
        issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 36, 0);
        issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 36, 0);
        repeat (2) @(posedge clk); #1;

        // DIV 5 / 0
        issue(1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 5, 0);
        repeat (2) @(posedge clk); #1;

        // Flush in cycle 10 of a running divide
        w0 = n_writes;
        ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_rs = 32'd1000; ex_rt = 32'd3;
        repeat (10) @(posedge clk); #1;
        ex_flush = 1'b1;
        @(posedge clk); #1;
        ex_flush = 1'b0;
        ex_div_signed = 1'b0; ex_rs = 32'd8; ex_rt = 32'd2;
        @(negedge clk);
        check("abort_clr1", {63'd0, div_clr}, 64'd1);
        check("abort_stall", {63'd0, div_stall}, 64'd0);
        check("abort_start", {63'd0, div_start}, 64'd0);
        @(negedge clk);
        check("abort_clr2", {63'd0, div_clr}, 64'd1);
        check("abort_no_accept", {63'd0, div_start}, 64'd0);
        check("flush_no_write", n_writes - w0, 0);
        @(posedge clk); #1;
        issue(1'b0, 32'd8, 32'd2, 32'd0, 32'd4, 36, 0);
        check("clr_idle", {63'd0, div_clr}, 64'd0);
        repeat (2) @(posedge clk); #1;

        // Hold for 3 cycles in DONE
        w0 = n_writes;
        issue(1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 36, 3);
        @(negedge clk);
        check("hold_one_write", n_writes - w0, 1);
        check("hold_no_restart", {63'd0, div_start}, 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of a divide
        w0 = n_writes;
        ex_div_req = 1'b1; ex_div_signed = 1'b0; ex_rs = 32'd77; ex_rt = 32'd5;
        repeat (6) @(posedge clk); #1;
        rst_n = 1'b0; ex_div_req = 1'b0;
        #1;
        check("mid_rst_start", {63'd0, div_start}, 64'd0);
        check("mid_rst_stall", {63'd0, div_stall}, 64'd0);
        check("mid_rst_a", {32'd0, div_a}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_rst_no_write", n_writes - w0, 0);
        @(posedge clk); #1;

`ifdef DIV_WATCHDOG_EN
        begin
            int n;
            force_busy = 1'b1;
            ex_div_req = 1'b1; ex_div_signed = 1'b1; ex_rs = 32'd1; ex_rt = 32'd1;
            n = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (div_err) break;
                n++;
            end
            check("wdog_cycle", n, 40);
            @(posedge clk); #1;
            ex_div_req = 1'b0;
            @(negedge clk);
            check("wdog_clr1", {63'd0, div_clr}, 64'd1);
            check("wdog_err_pulse", {63'd0, div_err}, 64'd0);
            @(negedge clk);
            check("wdog_clr2", {63'd0, div_clr}, 64'd1);
            @(negedge clk);
            check("wdog_idle", {62'd0, div_clr, div_start}, 64'd0);
            force_busy = 1'b0;
        end
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
